acc_burst_ctrl: RTL and testbench
=================================

// Module: acc_burst_ctrl
// PURPOSE
//  Upstream feeder and result collector for the accumulator (WIDTH-bit; ports clk/rst/in/ceAcu/out).
//  Buffers a valid/ready sample stream in a FIFO and drives the accumulator one sample per cycle.
//  After BURST_LEN samples it captures the sum and presents it on a valid/ready result port.
//  It then clears the accumulator for the next burst.
// PARAMETERS
//  WIDTH      8  data width of samples, accumulator and result
//  DEPTH      4  input FIFO entries; power of 2, >=2
//  BURST_LEN  4  samples summed per result, >=1
// PORTS
//  clk        in   1            clock; all logic on rising edge
//  rst        in   1            synchronous, active-high reset
//  s_valid    in   1            input sample valid
//  s_data     in   WIDTH        input sample
//  s_ready    out  1            FIFO can accept (= !full)
//  acc_in     out  WIDTH        to accumulator in (FIFO head)
//  acc_ce     out  1            to accumulator ceAcu; one pulse per sample
//  acc_clr    out  1            accumulator clear; system ORs it with rst into accumulator rst
//  acc_out    in   WIDTH        from accumulator out
//  res_valid  out  1            result valid; held until accepted
//  res_data   out  WIDTH        captured burst sum
//  res_ready  in   1            result consumer ready
//  fifo_level out  clog2(DEPTH)+1  FIFO occupancy
// BEHAVIOUR
//  Reset (rst=1 at edge):
//   - FSM=ACCUM; FIFO empty; sample count=0.
//   - Outputs s_ready=1, acc_ce=0, acc_clr=0, res_valid=0, res_data=0, fifo_level=0.
//   - Reset mid-burst discards buffered samples and the partial count; no result is produced.
//  FIFO:
//   - Push when s_valid&&s_ready. Pop when acc_ce=1.
//   - Registered storage, so a sample pushed at edge t is poppable from cycle t+1; no fall-through.
//   - s_ready=!full. When full, no push in that cycle even if a pop occurs.
//   - Simultaneous push+pop leaves the level unchanged. Pointers wrap mod DEPTH.
//  Accumulator contract: out<=out+in on an edge with ceAcu=1; sync clear on rst; sum wraps mod 2^WIDTH.
//  FSM:
//   - ACCUM:
//     - acc_ce=(FIFO not empty), acc_in=FIFO head.
//     - count++ on each acc_ce.
//     - acc_ce with count==BURST_LEN-1 -> SETTLE, count<=0.
//   - SETTLE (1 cycle): acc_ce=0; acc_out now holds the final sum; res_data<=acc_out, res_valid<=1 -> RESULT.
//   - RESULT: res_valid=1, res_data stable; acc_ce=0. res_valid&&res_ready -> CLEAR, res_valid<=0.
//   - CLEAR (1 cycle): acc_clr=1, acc_ce=0 -> ACCUM.
//  FIFO keeps accepting samples in every state while not full.
//  Latency with an empty FIFO and res_ready=1:
//   - Sample accepted at edge t gives acc_ce in cycle t+1.
//   - Last sample's acc_ce in cycle c -> res_valid from c+2.
//   - acc_clr in the cycle after the handshake; next acc_ce no earlier than the cycle after acc_clr.
//  Arithmetic: res_data = sum of BURST_LEN samples mod 2^WIDTH. No overflow flag.
//  acc_ce is never asserted outside ACCUM, so no sample leaks across bursts.
// TESTING
//  1. Reset; push 1,2,3,4 back-to-back, res_ready=1:
//     -> exactly 4 acc_ce cycles; res_data=10 with res_valid 1 cycle; acc_clr 1-cycle pulse next.
//  2. Push 200,100,0,0 -> res_data=44 (wrap mod 256).
//  3. res_ready=0, push 8 samples of 1 (DEPTH=4):
//     -> first result=4 held; s_ready=0 when fifo_level=4.
//     -> after res_ready=1: second result=4; acc_ce stays 0 during RESULT and CLEAR.
//  4. Push 5 every third cycle (s_valid gaps) -> count holds across gaps; res_data=20.
//  5. Push 7,7, then rst for 1 cycle, then push 1,1,1,1:
//     -> all outputs at reset values after rst; fifo_level=0; result=4.
//  6. BURST_LEN=1, push 9 then 3 -> two results 9 and 3, each followed by an acc_clr pulse.

Source files
------------

// File: rtl/acc_burst_ctrl_if.sv
// acc_burst_ctrl_if
//   Handshake bundle for acc_burst_ctrl: the sample input stream and the result output stream.
//   Signals:
//     s_valid / s_data / s_ready       : sample stream (producer -> controller)
//     res_valid / res_data / res_ready : result stream (controller -> consumer)
//   Modports:
//     master : the side that feeds samples and consumes results (system / testbench)
//     slave  : the controller itself
interface acc_burst_ctrl_if #(
  parameter int WIDTH = 8
) ();
  logic             s_valid;
  logic [WIDTH-1:0] s_data;
  logic             s_ready;
  logic             res_valid;
  logic [WIDTH-1:0] res_data;
  logic             res_ready;

  modport master (
    output s_valid, s_data, res_ready,
    input  s_ready, res_valid, res_data
  );

  modport slave (
    input  s_valid, s_data, res_ready,
    output s_ready, res_valid, res_data
  );
endinterface

// File: rtl/acc_burst_ctrl.sv
// acc_burst_ctrl
//   Feeds an external accumulator from a small sample FIFO, one sample per cycle,
//   and collects the sum after every BURST_LEN samples. The sum is presented on a
//   valid/ready result port. Once the result is accepted, the accumulator is cleared
//   for the next burst.
//   Ports:
//     clk, rst    : clock and synchronous active-high reset
//     bus         : slave side of acc_burst_ctrl_if (sample in, result out)
//     acc_in      : accumulator data input (FIFO head)
//     acc_ce      : accumulator enable; one pulse per consumed sample
//     acc_clr     : accumulator clear; the system ORs it with rst
//     acc_out     : accumulator running sum
//     fifo_level  : number of samples held in the FIFO
module acc_burst_ctrl #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 4,
  parameter int BURST_LEN = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  acc_burst_ctrl_if.slave        bus,
  output logic [WIDTH-1:0]       acc_in,
  output logic                   acc_ce,
  output logic                   acc_clr,
  input  logic [WIDTH-1:0]       acc_out,
  output logic [$clog2(DEPTH):0] fifo_level
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

  typedef enum logic [1:0] {ACCUM, SETTLE, RESULT, CLEAR} state_t;

  state_t           state_reg;
  logic [CW-1:0]    count_reg;
  logic             res_valid_reg;
  logic [WIDTH-1:0] res_data_reg;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW:0]      level_reg;

  logic full;
  logic empty;
  logic push;
  logic pop;

  assign full  = (level_reg == (AW+1)'(DEPTH));
  assign empty = (level_reg == '0);
  // A full FIFO refuses a push even when a pop happens in the same cycle.
  assign push  = bus.s_valid && !full;
  assign pop   = acc_ce;

  // Samples are only consumed while accumulating, so nothing leaks across bursts.
  assign acc_ce        = (state_reg == ACCUM) && !empty;
  assign acc_clr       = (state_reg == CLEAR);
  assign acc_in        = mem[rd_ptr_reg];
  assign bus.s_ready   = !full;
  assign bus.res_valid = res_valid_reg;
  assign bus.res_data  = res_data_reg;
  assign fifo_level    = level_reg;

  // Storage needs no reset; occupancy is tracked by level_reg.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= bus.s_data;
    end
  end

  // Pointers are AW bits wide, so they wrap mod DEPTH on their own.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      case ({push, pop})
        2'b10:   level_reg <= level_reg + (AW+1)'(1);
        2'b01:   level_reg <= level_reg - (AW+1)'(1);
        default: level_reg <= level_reg;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ACCUM;
      count_reg     <= '0;
      res_valid_reg <= 1'b0;
      res_data_reg  <= '0;
    end else begin
      case (state_reg)
        ACCUM: begin
          if (acc_ce) begin
            if (count_reg == CW'(BURST_LEN - 1)) begin
              count_reg <= '0;
              state_reg <= SETTLE;
            end else begin
              count_reg <= count_reg + CW'(1);
            end
          end
        end
        // The last sample's add lands on the edge entering this state,
        // so acc_out is final here.
        SETTLE: begin
          res_data_reg  <= acc_out;
          res_valid_reg <= 1'b1;
          state_reg     <= RESULT;
        end
        RESULT: begin
          if (bus.res_ready) begin
            res_valid_reg <= 1'b0;
            state_reg     <= CLEAR;
          end
        end
        CLEAR: begin
          state_reg <= ACCUM;
        end
        default: begin
          state_reg <= ACCUM;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_acc_burst_ctrl.sv
module tb_acc_burst_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  acc_burst_ctrl_if #(.WIDTH(8)) bus0 ();
  acc_burst_ctrl_if #(.WIDTH(8)) bus1 ();

  logic [7:0] acc_in0, acc_out0, acc_in1, acc_out1;
  logic       acc_ce0, acc_clr0, acc_ce1, acc_clr1;
  logic [2:0] level0, level1;

  acc_burst_ctrl #(.WIDTH(8), .DEPTH(4), .BURST_LEN(4)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0), .acc_in(acc_in0), .acc_ce(acc_ce0),
    .acc_clr(acc_clr0), .acc_out(acc_out0), .fifo_level(level0)
  );

  acc_burst_ctrl #(.WIDTH(8), .DEPTH(4), .BURST_LEN(1)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1), .acc_in(acc_in1), .acc_ce(acc_ce1),
    .acc_clr(acc_clr1), .acc_out(acc_out1), .fifo_level(level1)
  );

  // External accumulators: clear on rst or acc_clr, add on ce, wrap mod 256.
  always_ff @(posedge clk) begin
    if (rst || acc_clr0) acc_out0 <= '0;
    else if (acc_ce0)    acc_out0 <= acc_out0 + acc_in0;
  end
  always_ff @(posedge clk) begin
    if (rst || acc_clr1) acc_out1 <= '0;
    else if (acc_ce1)    acc_out1 <= acc_out1 + acc_in1;
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Scoreboard and monitors, sampled on the falling edge.
  logic [7:0] part0;
  int         n0;
  logic [7:0] q0[$];
  logic [7:0] q1[$];
  logic [7:0] e;
  int res_cnt0 = 0, res_cnt1 = 0, ce_cnt0 = 0, unexp0 = 0, unexp1 = 0;
  int leak0 = 0, sready_bad0 = 0, clr_cnt1 = 0, cyc = 0, last_ce_cyc = 0;
  int lat_res = 0, rv_run = 0, rv_len = 0, clr_run = 0, clr_len = 0;

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      part0 = '0;
      n0 = 0;
      q0.delete();
      q1.delete();
    end else begin
      if (bus0.s_valid && bus0.s_ready) begin
        part0 = part0 + bus0.s_data;
        n0++;
        if (n0 == 4) begin
          q0.push_back(part0);
          part0 = '0;
          n0 = 0;
        end
      end
      if (bus0.res_valid && bus0.res_ready) begin
        res_cnt0++;
        if (q0.size() == 0) unexp0++;
        else begin
          e = q0.pop_front();
          $display("burst result %0d: got %0d expected %0d", res_cnt0, bus0.res_data, e);
          chk("res_data", 32'(bus0.res_data), 32'(e));
        end
      end
      if (acc_ce0) begin
        ce_cnt0++;
        last_ce_cyc = cyc;
      end
      if (acc_ce0 && (bus0.res_valid || acc_clr0)) leak0++;
      if (bus0.s_ready !== (level0 != 3'd4)) sready_bad0++;
      if (bus0.res_valid) begin
        if (rv_run == 0) lat_res = cyc - last_ce_cyc;
        rv_run++;
      end else if (rv_run != 0) begin
        rv_len = rv_run;
        rv_run = 0;
      end
      if (acc_clr0) clr_run++;
      else if (clr_run != 0) begin
        clr_len = clr_run;
        clr_run = 0;
      end

      if (bus1.s_valid && bus1.s_ready) q1.push_back(bus1.s_data);
      if (bus1.res_valid && bus1.res_ready) begin
        res_cnt1++;
        if (q1.size() == 0) unexp1++;
        else begin
          e = q1.pop_front();
          $display("single result %0d: got %0d expected %0d", res_cnt1, bus1.res_data, e);
          chk("res1_data", 32'(bus1.res_data), 32'(e));
        end
      end
      if (acc_clr1) clr_cnt1++;
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push0(input logic [7:0] v);
    int b;
    logic ok;
    bus0.s_valid = 1'b1;
    bus0.s_data  = v;
    b = 0;
    do begin
      ok = bus0.s_ready;
      @(posedge clk);
      #1;
      b++;
    end while (!ok && b < 200);
    if (!ok) chk("push0_timeout", 32'(b), 32'(0));
    bus0.s_valid = 1'b0;
  endtask

  task automatic push1(input logic [7:0] v);
    int b;
    logic ok;
    bus1.s_valid = 1'b1;
    bus1.s_data  = v;
    b = 0;
    do begin
      ok = bus1.s_ready;
      @(posedge clk);
      #1;
      b++;
    end while (!ok && b < 200);
    if (!ok) chk("push1_timeout", 32'(b), 32'(0));
    bus1.s_valid = 1'b0;
  endtask

  task automatic wait_res0(input int n);
    int b = 0;
    while (res_cnt0 < n && b < 300) begin
      idle(1);
      b++;
    end
    chk("wait_res0", 32'(res_cnt0), 32'(n));
  endtask

  task automatic wait_res1(input int n);
    int b = 0;
    while (res_cnt1 < n && b < 300) begin
      idle(1);
      b++;
    end
    chk("wait_res1", 32'(res_cnt1), 32'(n));
  endtask

  task automatic check_reset0(input string pfx);
    chk({pfx, "_s_ready"},   32'(bus0.s_ready),   32'(1));
    chk({pfx, "_acc_ce"},    32'(acc_ce0),        32'(0));
    chk({pfx, "_acc_clr"},   32'(acc_clr0),       32'(0));
    chk({pfx, "_res_valid"}, 32'(bus0.res_valid), 32'(0));
    chk({pfx, "_res_data"},  32'(bus0.res_data),  32'(0));
    chk({pfx, "_level"},     32'(level0),         32'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int ce_base;

  initial begin
    bus0.s_valid = 1'b0; bus0.s_data = '0; bus0.res_ready = 1'b1;
    bus1.s_valid = 1'b0; bus1.s_data = '0; bus1.res_ready = 1'b1;
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    check_reset0("rst");

    // 1: 1+2+3+4 back-to-back
    ce_base = ce_cnt0;
    push0(8'd1);
    chk("t1_first_ce", 32'(acc_ce0), 32'(1));
    push0(8'd2);
    push0(8'd3);
    push0(8'd4);
    wait_res0(1);
    idle(4);
    chk("t1_ce_count", 32'(ce_cnt0 - ce_base), 32'(4));
    chk("t1_res_latency", 32'(lat_res), 32'(2));
    chk("t1_valid_len", 32'(rv_len), 32'(1));
    chk("t1_clr_len", 32'(clr_len), 32'(1));

    // 2: wrap mod 256
    push0(8'd200);
    push0(8'd100);
    push0(8'd0);
    push0(8'd0);
    wait_res0(2);
    idle(3);

    // 3: consumer stalled, FIFO fills behind the held result
    bus0.res_ready = 1'b0;
    repeat (8) push0(8'd1);
    idle(4);
    chk("t3_full_level", 32'(level0), 32'(4));
    chk("t3_full_ready", 32'(bus0.s_ready), 32'(0));
    chk("t3_held_valid", 32'(bus0.res_valid), 32'(1));
    chk("t3_held_data", 32'(bus0.res_data), 32'(4));
    bus0.res_ready = 1'b1;
    wait_res0(4);
    idle(4);

    // 4: sparse input
    ce_base = ce_cnt0;
    repeat (4) begin
      push0(8'd5);
      idle(2);
    end
    wait_res0(5);
    idle(3);
    chk("t4_ce_count", 32'(ce_cnt0 - ce_base), 32'(4));

    // 5: reset mid-burst
    push0(8'd7);
    push0(8'd7);
    idle(2);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    check_reset0("midrst");
    repeat (4) push0(8'd1);
    wait_res0(6);
    idle(4);

    // 6: BURST_LEN=1
    push1(8'd9);
    push1(8'd3);
    wait_res1(2);
    idle(3);
    chk("t6_clr_pulses", 32'(clr_cnt1), 32'(2));

    chk("unexpected_res0", 32'(unexp0), 32'(0));
    chk("unexpected_res1", 32'(unexp1), 32'(0));
    chk("ce_leak", 32'(leak0), 32'(0));
    chk("s_ready_vs_level", 32'(sready_bad0), 32'(0));
    chk("pending_res0", 32'(q0.size()), 32'(0));
    chk("pending_res1", 32'(q1.size()), 32'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
